// File: rtl/uart_tx_fifo.sv
// Transmit byte queue feeding a UART engine via a load/txrdy handshake.
// Define TXFIFO_OVF_EN to add the sticky overflow flag (o_ovf / i_ovf_clr).
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wr_en,
    input  logic [7:0]    i_wr_data,
    input  logic          i_txrdy,
`ifdef TXFIFO_OVF_EN
    input  logic          i_ovf_clr,
    output logic          o_ovf,
`endif
    output logic          o_load,
    output logic [7:0]    o_tx_data,
    output logic [AW:0]   o_count,
    output logic          o_empty,
    output logic          o_full
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_RDY  = 2'd3
    } state_t;

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_tx_data;
    logic          r_load;
    state_t        r_state;
    state_t        w_next;
    logic          w_pop;
    logic          w_push;
    logic          w_empty;
    logic          w_full;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == LP_DEPTH);

    // A pop frees a slot on the same edge, so a write while full still lands.
    assign w_pop  = (r_state == S_IDLE) && !w_empty && i_txrdy;
    assign w_push = i_wr_en && (!w_full || w_pop);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (w_pop)     w_next = S_LOAD;
            S_LOAD:                     w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!i_txrdy)  w_next = S_WAIT_RDY;
            S_WAIT_RDY:  if (i_txrdy)   w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_load  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_load  <= (w_next == S_LOAD);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_reset) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_tx_data <= 8'h00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_tx_data <= r_mem[r_rd_ptr];
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

`ifdef TXFIFO_OVF_EN
    logic r_ovf;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ovf <= 1'b0;
        end else if (i_wr_en && !w_push) begin
            r_ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign o_ovf = r_ovf;
`endif

    assign o_load    = r_load;
    assign o_tx_data = r_tx_data;
    assign o_count   = r_count;
    assign o_empty   = w_empty;
    assign o_full    = w_full;

endmodule
